cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_lfsr6.sv | 26 ++
 rtl/cam_stream_gen.sv | 158 +++++++++++++++
 tb/tb_cam_stream_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera stream generator.
// LFSR helper is only referenced when CAM_STREAM_LFSR_EN is defined.
package cam_pkg;

    localparam int                 PIX_W     = 6;
    localparam logic [PIX_W-1:0]   LFSR_SEED = 6'h01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BP     = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FP     = 3'd4
    } cam_state_t;

    typedef enum logic [1:0] {
        MODE_XRAMP = 2'd0,
        MODE_YRAMP = 2'd1,
        MODE_CONST = 2'd2,
        MODE_LFSR  = 2'd3
    } cam_mode_t;

    // x^6+x^5+1, XNOR feedback so the all-zero state is never stuck
    function automatic logic [PIX_W-1:0] lfsr6_next(input logic [PIX_W-1:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

endpackage

// File: rtl/cam_lfsr6.sv
// 6-bit pattern LFSR: synchronous reseed has priority over step.
module cam_lfsr6
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic             i_reseed,
    output logic [PIX_W-1:0] o_value
);

    logic [PIX_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_step) begin
            r_lfsr <= lfsr6_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/cam_stream_gen.sv
// Camera-style frame/line timing generator with selectable test patterns.
// Optional LFSR pattern (mode 3) built only when CAM_STREAM_LFSR_EN is defined.
//
// state  | meaning
// IDLE   | waiting for enable, outputs quiet
// SYNC   | vsync lines
// BP     | blank lines after vsync
// ACTIVE | pixel lines, href during first H_ACTIVE clocks
// FP     | blank lines after last active line; frame ends here
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] const_px,
    output logic             vsync,
    output logic             href,
    output logic [PIX_W-1:0] din,
    output logic             frame_done,
    output logic             busy
);

    localparam int L      = H_ACTIVE + H_BLANK;
    localparam int HW     = (L > 1) ? $clog2(L) : 1;
    localparam int VMAX_A = (V_SYNC > V_BP) ? V_SYNC : V_BP;
    localparam int VMAX_B = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
    localparam int VMAX   = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int VW     = (VMAX > 1) ? $clog2(VMAX) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(L - 1);

    cam_state_t       r_state, w_nstate, w_after_frame;
    logic [HW-1:0]    r_hcnt, w_nhcnt;
    logic [VW-1:0]    r_vcnt, w_nvcnt;
    cam_mode_t        r_mode;
    logic [PIX_W-1:0] r_const;
    logic             r_vsync, r_href, r_frame_done, r_busy;
    logic [PIX_W-1:0] r_din, w_npix, w_lfsr;
    logic             w_nhref, w_nlast, w_sync_entry;
    int               w_lines;

    assign w_after_frame = enable ? ST_SYNC : ST_IDLE;

    always_comb begin
        w_lines = V_SYNC;
        case (r_state)
            ST_BP:     w_lines = V_BP;
            ST_ACTIVE: w_lines = V_ACTIVE;
            ST_FP:     w_lines = V_FP;
            default:   w_lines = V_SYNC;
        endcase
    end

    // Zero-length BP/FP are skipped by never entering them.
    always_comb begin
        w_nstate = r_state;
        w_nhcnt  = r_hcnt;
        w_nvcnt  = r_vcnt;
        if (r_state == ST_IDLE) begin
            w_nhcnt = '0;
            w_nvcnt = '0;
            if (enable) w_nstate = ST_SYNC;
        end else begin
            w_nhcnt = (r_hcnt == H_LAST) ? '0 : r_hcnt + 1'b1;
            if (r_hcnt == H_LAST) begin
                if (32'(r_vcnt) == w_lines - 1) begin
                    w_nvcnt = '0;
                    case (r_state)
                        ST_SYNC:   w_nstate = (V_BP > 0) ? ST_BP : ST_ACTIVE;
                        ST_BP:     w_nstate = ST_ACTIVE;
                        ST_ACTIVE: w_nstate = (V_FP > 0) ? ST_FP : w_after_frame;
                        default:   w_nstate = w_after_frame;
                    endcase
                end else begin
                    w_nvcnt = r_vcnt + 1'b1;
                end
            end
        end
    end

    // Outputs are registered from the next-cycle position so they line up with the state.
    assign w_sync_entry = (w_nstate == ST_SYNC) && (r_state != ST_SYNC);
    assign w_nhref      = (w_nstate == ST_ACTIVE) && (32'(w_nhcnt) < H_ACTIVE);
    assign w_nlast      = (w_nhcnt == H_LAST) &&
                          (((w_nstate == ST_FP) && (32'(w_nvcnt) == V_FP - 1)) ||
                           ((V_FP == 0) && (w_nstate == ST_ACTIVE) &&
                            (32'(w_nvcnt) == V_ACTIVE - 1)));

`ifdef CAM_STREAM_LFSR_EN
    cam_lfsr6 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_step   (w_nhref),
        .i_reseed (w_sync_entry),
        .o_value  (w_lfsr)
    );
`else
    assign w_lfsr = '0;
`endif

    always_comb begin
        w_npix = PIX_W'(w_nhcnt);
        case (r_mode)
            MODE_YRAMP: w_npix = PIX_W'(w_nvcnt);
            MODE_CONST: w_npix = r_const;
`ifdef CAM_STREAM_LFSR_EN
            MODE_LFSR:  w_npix = w_lfsr;
`else
            MODE_LFSR:  w_npix = PIX_W'(w_nhcnt) | (w_lfsr & '0);
`endif
            default:    w_npix = PIX_W'(w_nhcnt);
        endcase
        if (!w_nhref) w_npix = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_mode       <= MODE_XRAMP;
            r_const      <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_din        <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nstate;
            r_hcnt       <= w_nhcnt;
            r_vcnt       <= w_nvcnt;
            if (w_sync_entry) begin
                r_mode  <= cam_mode_t'(mode);
                r_const <= const_px;
            end
            r_vsync      <= (w_nstate == ST_SYNC);
            r_href       <= w_nhref;
            r_din        <= w_npix;
            r_frame_done <= w_nlast;
            r_busy       <= (w_nstate != ST_IDLE);
        end
    end

    assign vsync      = r_vsync;
    assign href       = r_href;
    assign din        = r_din;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen on a 6x5-line frame; a frame-position model
// feeds an expected-output queue that is popped against the DUT every clock.
module tb_cam_stream_gen;

    localparam int HA    = 4;
    localparam int HB    = 2;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VA    = 2;
    localparam int VF    = 1;
    localparam int L     = HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * L;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] const_px = 6'd0;
    logic       vsync, href, frame_done, busy;
    logic [5:0] din;

    cam_stream_gen #(
        .H_ACTIVE (HA), .H_BLANK (HB), .V_SYNC (VS),
        .V_BP     (VB), .V_ACTIVE(VA), .V_FP   (VF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .const_px   (const_px),
        .vsync      (vsync),
        .href       (href),
        .din        (din),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic [5:0] px;
        logic       fd;
        logic       bz;
    } obs_t;

    obs_t       exp_q[$];
    int         fd_cyc[$];
    logic [5:0] pix_q[$];
    logic [5:0] seq_exp [8];
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         start;

    // frame-position model
    bit         m_run = 1'b0;
    int         m_pos = 0;
    logic [1:0] m_mode = 2'd0;
    logic [5:0] m_const = 6'd0;
    logic [5:0] m_lfsr = 6'h01;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        obs_t e;
        int   line, h;
        bit   act;
        if (!rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_lfsr = 6'h01;
        end else if (!m_run || m_pos == FRAME - 1) begin
            if (enable) begin
                m_run   = 1'b1;
                m_pos   = 0;
                m_mode  = mode;
                m_const = const_px;
                m_lfsr  = 6'h01;
            end else begin
                m_run = 1'b0;
                m_pos = 0;
            end
        end else begin
            m_pos++;
        end
        line = m_pos / L;
        h    = m_pos % L;
        act  = m_run && line >= VS + VB && line < VS + VB + VA;
        e.vs = m_run && line < VS;
        e.hr = act && h < HA;
        e.fd = m_run && m_pos == FRAME - 1;
        e.bz = m_run;
        e.px = 6'd0;
        if (e.hr) begin
            case (m_mode)
                2'd1: e.px = 6'(line - VS - VB);
                2'd2: e.px = m_const;
                2'd3: begin
`ifdef CAM_STREAM_LFSR_EN
                    e.px   = m_lfsr;
                    m_lfsr = {m_lfsr[4:0], ~(m_lfsr[5] ^ m_lfsr[4])};
`else
                    e.px = 6'(h);
`endif
                end
                default: e.px = 6'(h);
            endcase
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input string tag);
        obs_t e;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        e = exp_q.pop_front();
        check(tag, {vsync, href, din, frame_done, busy}, e);
        if (frame_done) fd_cyc.push_back(cyc);
        if (href) pix_q.push_back(din);
    endtask

    initial begin
`ifdef CAM_STREAM_LFSR_EN
        seq_exp = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
`else
        seq_exp = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd1, 6'd2, 6'd3};
`endif
        // reset and idle
        repeat (3) tick("reset");
        rst = 1'b1;
        repeat (2) tick("idle");

        // x ramp, three back-to-back frames
        fd_cyc.delete();
        pix_q.delete();
        enable = 1'b1;
        mode   = 2'd0;
        start  = cyc;
        repeat (3 * FRAME) tick("ramp");
        enable = 1'b0;
        repeat (4) tick("ramp_stop");
        check("fd_count", fd_cyc.size(), 3);
        for (int i = 0; i < fd_cyc.size(); i++)
            check("fd_spacing", fd_cyc[i] - start, FRAME * (i + 1));
        check("ramp_px_count", pix_q.size(), 24);
        for (int i = 0; i < pix_q.size() && i < 8; i++)
            check("ramp_px", pix_q[i], i % 4);

        // constant pattern, mode change mid-frame, enable dropped in ACTIVE of frame 2
        fd_cyc.delete();
        pix_q.delete();
        mode     = 2'd2;
        const_px = 6'h2A;
        enable   = 1'b1;
        start    = cyc;
        repeat (10) tick("const");
        mode = 2'd0;
        repeat (FRAME + 5) tick("const");
        enable = 1'b0;
        repeat (15) tick("drop");
        check("drop_fd_count", fd_cyc.size(), 2);
        if (fd_cyc.size() == 2) check("drop_fd_pos", fd_cyc[1] - start, 2 * FRAME);
        tick("drop_after");
        check("busy_fall", busy, 1'b0);
        repeat (5) tick("drop_quiet");
        check("const_px_count", pix_q.size(), 16);
        for (int i = 0; i < pix_q.size() && i < 16; i++)
            check("const_then_ramp", pix_q[i], (i < 8) ? 6'h2A : 6'(i % 4));

        // async reset during BP
        enable = 1'b1;
        mode   = 2'd0;
        repeat (8) tick("pre_rst");
        #2 rst = 1'b0;
        #1 check("rst_async", {vsync, href, din, frame_done, busy}, 10'd0);
        repeat (2) tick("in_rst");
        rst = 1'b1;
        tick("restart");
        check("vsync_restart", vsync, 1'b1);
        repeat (FRAME - 1) tick("restart");
        enable = 1'b0;
        repeat (3) tick("restart_end");

        // pseudo-random pattern over two frames
        pix_q.delete();
        mode   = 2'd3;
        enable = 1'b1;
        repeat (FRAME + 1) tick("lfsr");
        repeat (FRAME - 1) tick("lfsr");
        enable = 1'b0;
        repeat (2) tick("lfsr_end");
        check("lfsr_px_count", pix_q.size(), 16);
        for (int i = 0; i < pix_q.size() && i < 16; i++)
            check("lfsr_seq", pix_q[i], seq_exp[i % 8]);

        // y ramp, single frame
        pix_q.delete();
        mode   = 2'd1;
        enable = 1'b1;
        tick("yramp");
        enable = 1'b0;
        repeat (FRAME + 1) tick("yramp");
        check("yramp_px_count", pix_q.size(), 8);
        for (int i = 0; i < pix_q.size() && i < 8; i++)
            check("yramp_px", pix_q[i], i / 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
